// File: rtl/raster_dispatch.sv
// raster_dispatch: triangle FIFO + rasterizer issue handshake + per-frame FB/Z clear sweep
module raster_dispatch #(
  parameter int TRI_W = 312,
  parameter int DEPTH = 4,
  parameter int FB_PIXELS = 76800,
  parameter logic [7:0] Z_CLEAR = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tri_valid,
  output logic             o_tri_ready,
  input  logic [TRI_W-1:0] i_tri_data,
  input  logic             i_frame_start,
  input  logic [11:0]      i_clear_color,
  input  logic             i_frame_end,
  output logic             o_frame_done,
  output logic             o_clearing,
  output logic             o_rast_valid,
  input  logic             i_rast_busy,
  output logic [TRI_W-1:0] o_rast_tri,
  input  logic [16:0]      i_rast_fb_addr,
  input  logic             i_rast_fb_we,
  input  logic [11:0]      i_rast_fb_pixel,
  input  logic [16:0]      i_rast_zb_addr,
  input  logic             i_rast_zb_we,
  input  logic [7:0]       i_rast_zb_data,
  output logic [16:0]      o_fb_addr,
  output logic             o_fb_we,
  output logic [11:0]      o_fb_pixel,
  output logic [16:0]      o_zb_addr,
  output logic             o_zb_we,
  output logic [7:0]       o_zb_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] LAST = 17'(FB_PIXELS - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT_BUSY = 3'd2, S_WAIT_DONE = 3'd3, S_CLEAR = 3'd4;
  logic [2:0] state, state_nxt;
  logic [TRI_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [16:0] cnt;
  logic [11:0] req_color, sweep_color;
  logic pending_clear, pending_end;
  logic empty, full, push, pop, start_clear, sweep_last;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_tri_ready = !full;
  assign push = i_tri_valid && !full;
  assign start_clear = state == S_IDLE && pending_clear;
  assign pop = state == S_IDLE && !pending_clear && !empty;
  assign sweep_last = state == S_CLEAR && cnt == LAST;
  assign o_clearing = state == S_CLEAR;
  assign o_rast_valid = state == S_ISSUE;
  assign o_frame_done = pending_end && state == S_IDLE && empty && !pending_clear && !i_rast_busy;
  // Clear engine owns both memory ports for the whole sweep.
  assign o_fb_addr = o_clearing ? cnt : i_rast_fb_addr;
  assign o_fb_we = o_clearing ? 1'b1 : i_rast_fb_we;
  assign o_fb_pixel = o_clearing ? sweep_color : i_rast_fb_pixel;
  assign o_zb_addr = o_clearing ? cnt : i_rast_zb_addr;
  assign o_zb_we = o_clearing ? 1'b1 : i_rast_zb_we;
  assign o_zb_data = o_clearing ? Z_CLEAR : i_rast_zb_data;
  always_comb begin
    state_nxt = S_IDLE;
    state_nxt = state == S_IDLE ? (pending_clear ? S_CLEAR : (empty ? S_IDLE : S_ISSUE)) :
                state == S_ISSUE ? S_WAIT_BUSY :
                state == S_WAIT_BUSY ? (i_rast_busy ? S_WAIT_DONE : S_WAIT_BUSY) :
                state == S_WAIT_DONE ? (i_rast_busy ? S_WAIT_DONE : S_IDLE) :
                state == S_CLEAR ? (sweep_last ? S_IDLE : S_CLEAR) : S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_tri_data;
  end
  // pending_clear drops on sweep entry so a start arriving mid-sweep queues another sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      req_color <= '0;
      sweep_color <= '0;
      pending_clear <= 1'b0;
      pending_end <= 1'b0;
      o_rast_tri <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_rast_tri <= mem[rd_ptr[AW-1:0]];
      end
      pending_clear <= i_frame_start || (pending_clear && !start_clear);
      pending_end <= i_frame_end || (pending_end && !o_frame_done);
      if (i_frame_start) req_color <= i_clear_color;
      if (start_clear) sweep_color <= req_color;
      if (state == S_CLEAR) cnt <= sweep_last ? '0 : cnt + 17'd1;
    end
  end
endmodule

// File: tb/tb_raster_dispatch.sv
// tb_raster_dispatch: randomized scoreboard bench with a behavioural rasterizer and clear-sweep model
module tb_raster_dispatch;
  localparam int TRI_W = 312;
  localparam int DEPTH = 4;
  localparam int FB_PIXELS = 76800;
  logic i_clk = 0, i_rst_n;
  logic i_tri_valid, o_tri_ready, i_frame_start, i_frame_end, o_frame_done, o_clearing;
  logic o_rast_valid, i_rast_busy;
  logic [TRI_W-1:0] i_tri_data, o_rast_tri;
  logic [11:0] i_clear_color, i_rast_fb_pixel, o_fb_pixel;
  logic [16:0] i_rast_fb_addr, i_rast_zb_addr, o_fb_addr, o_zb_addr;
  logic i_rast_fb_we, i_rast_zb_we, o_fb_we, o_zb_we;
  logic [7:0] i_rast_zb_data, o_zb_data;

  raster_dispatch #(.TRI_W(TRI_W), .DEPTH(DEPTH), .FB_PIXELS(FB_PIXELS), .Z_CLEAR(8'hFF)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tri_valid(i_tri_valid), .o_tri_ready(o_tri_ready),
    .i_tri_data(i_tri_data), .i_frame_start(i_frame_start), .i_clear_color(i_clear_color),
    .i_frame_end(i_frame_end), .o_frame_done(o_frame_done), .o_clearing(o_clearing),
    .o_rast_valid(o_rast_valid), .i_rast_busy(i_rast_busy), .o_rast_tri(o_rast_tri),
    .i_rast_fb_addr(i_rast_fb_addr), .i_rast_fb_we(i_rast_fb_we), .i_rast_fb_pixel(i_rast_fb_pixel),
    .i_rast_zb_addr(i_rast_zb_addr), .i_rast_zb_we(i_rast_zb_we), .i_rast_zb_data(i_rast_zb_data),
    .o_fb_addr(o_fb_addr), .o_fb_we(o_fb_we), .o_fb_pixel(o_fb_pixel),
    .o_zb_addr(o_zb_addr), .o_zb_we(o_zb_we), .o_zb_data(o_zb_data));

  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [TRI_W-1:0] exp_q[$];
  logic [TRI_W-1:0] cur;
  bit have_cur = 0, unstable = 0, prev_busy = 0, stall = 0;
  int last_fall_cyc = -10, last_valid_cyc = 0, done_cnt = 0, accept_cyc = 0;
  int sweeps_done = 0, starts_req = 0, clr_idx = 0, clr_bad = 0;
  logic [11:0] exp_color = 0;

  task automatic check(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TRI_W-1:0] rnd_tri();
    logic [TRI_W-1:0] t = '0;
    for (int i = 0; i < 10; i++) t = {t[TRI_W-33:0], 32'($urandom())};
    return t;
  endfunction

  // Behavioural rasterizer: busy one cycle after valid, held for a random span or while stalled.
  initial begin
    int len;
    i_rast_busy = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_rast_valid) begin
        len = $urandom_range(1, 5);
        @(posedge i_clk);
        #1 i_rast_busy = 1;
        repeat (len) @(posedge i_clk);
        while (stall && i_rst_n) @(posedge i_clk);
        #1 i_rast_busy = 0;
        last_fall_cyc = cyc;
      end
    end
  end

  // Monitor: scoreboard pops on issue; clear sweep and frame_done are checked against the model.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      clr_idx = 0;
      clr_bad = 0;
      have_cur = 0;
      prev_busy = 0;
    end else begin
      if (o_rast_valid) begin
        last_valid_cyc = cyc;
        check("issue_busy_low", i_rast_busy, 0);
        check("issue_after_sweeps", sweeps_done, starts_req);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_issue: got tri %0h expected no issue", o_rast_tri);
        end else begin
          cur = exp_q.pop_front();
          check("rast_tri_order", o_rast_tri, cur);
          have_cur = 1;
          unstable = 0;
        end
      end
      if (have_cur && o_rast_tri !== cur) unstable = 1;
      if (prev_busy && !i_rast_busy && have_cur) begin
        check("rast_tri_stable", unstable, 0);
        have_cur = 0;
      end
      prev_busy = i_rast_busy;
      if (o_frame_done) begin
        done_cnt++;
        check("done_timing", cyc, last_fall_cyc + 1);
        check("done_queue_empty", exp_q.size(), 0);
      end
      if (o_clearing) begin
        if (o_fb_addr !== 17'(clr_idx) || o_fb_we !== 1'b1 || o_fb_pixel !== exp_color ||
            o_zb_addr !== 17'(clr_idx) || o_zb_we !== 1'b1 || o_zb_data !== 8'hFF) clr_bad++;
        clr_idx++;
      end else if (clr_idx != 0) begin
        check("clear_len", clr_idx, FB_PIXELS);
        check("clear_bad_writes", clr_bad, 0);
        sweeps_done++;
        clr_idx = 0;
        clr_bad = 0;
      end
    end
  end

  task automatic push(input logic [TRI_W-1:0] d, output int waited);
    i_tri_valid = 1;
    i_tri_data = d;
    waited = 0;
    forever begin
      @(negedge i_clk);
      if (o_tri_ready) break;
      waited++;
      if (waited > 500) begin
        check("push_accept", 0, 1);
        @(posedge i_clk);
        #1 i_tri_valid = 0;
        return;
      end
    end
    @(posedge i_clk);
    #1;
    exp_q.push_back(d);
    accept_cyc = cyc;
    i_tri_valid = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input string name);
    int w = 0;
    while (i_rast_busy !== v && w < 200) begin tick(1); w++; end
    check(name, i_rast_busy, v);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || have_cur || i_rast_busy) && w < 5000) begin tick(1); w++; end
    check("drain", exp_q.size() + int'(have_cur), 0);
    tick(3);
  endtask

  task automatic frame_start(input logic [11:0] c);
    i_frame_start = 1;
    i_clear_color = c;
    exp_color = c;
    starts_req++;
    tick(1);
    i_frame_start = 0;
    i_clear_color = 12'h123;
  endtask

  initial begin
    int w, cnt0;
    i_rst_n = 0; i_tri_valid = 0; i_tri_data = '0; i_frame_start = 0; i_frame_end = 0;
    i_clear_color = '0; i_rast_fb_addr = '0; i_rast_fb_we = 0; i_rast_fb_pixel = '0;
    i_rast_zb_addr = '0; i_rast_zb_we = 0; i_rast_zb_data = '0;
    tick(3);
    check("rst_ready", o_tri_ready, 1);
    check("rst_valid", o_rast_valid, 0);
    check("rst_clearing", o_clearing, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_tri", o_rast_tri, 0);
    i_rst_n = 1;
    tick(2);
    i_rast_fb_addr = 17'd500; i_rast_fb_we = 1; i_rast_fb_pixel = 12'hABC;
    i_rast_zb_addr = 17'd777; i_rast_zb_we = 1; i_rast_zb_data = 8'h5A;
    #1;
    check("pass_fb_addr", o_fb_addr, 17'd500);
    check("pass_fb_we", o_fb_we, 1);
    check("pass_fb_pixel", o_fb_pixel, 12'hABC);
    check("pass_zb_addr", o_zb_addr, 17'd777);
    check("pass_zb_data", o_zb_data, 8'h5A);
    tick(1);
    i_rast_fb_addr = 17'd3; i_rast_zb_addr = 17'd9;
    frame_start(12'h0F0);
    w = 0;
    while (!o_clearing && w < 10) begin tick(1); w++; end
    check("clear_start", o_clearing, 1);
    tick(20);
    for (int i = 0; i < 3; i++) push(rnd_tri(), w);
    w = 0;
    while (sweeps_done < 1 && w < 80000) begin tick(1); w++; end
    check("sweep_done", sweeps_done, 1);
    i_rast_fb_we = 0; i_rast_zb_we = 0;
    drain();
    stall = 1;
    push(rnd_tri(), w);
    wait_busy(1, "stall_busy");
    for (int i = 0; i < DEPTH; i++) begin
      push(rnd_tri(), w);
      check("push_nowait", w, 0);
    end
    @(negedge i_clk);
    check("ready_full", o_tri_ready, 0);
    fork
      begin push(rnd_tri(), w); end
      begin tick(10); stall = 0; end
    join
    check("fifth_waited", w > 0, 1);
    check("fifth_after_pop", accept_cyc, last_valid_cyc + 1);
    drain();
    stall = 1;
    push(rnd_tri(), w);
    wait_busy(1, "end_busy");
    push(rnd_tri(), w);
    i_frame_end = 1;
    tick(1);
    i_frame_end = 0;
    cnt0 = done_cnt;
    tick(15);
    check("no_early_done", done_cnt, cnt0);
    stall = 0;
    drain();
    tick(5);
    check("done_once", done_cnt, cnt0 + 1);
    for (int i = 0; i < 24; i++) begin
      push(rnd_tri(), w);
      tick($urandom_range(0, 3));
    end
    drain();
    stall = 1;
    push(rnd_tri(), w);
    wait_busy(1, "rst_busy");
    push(rnd_tri(), w);
    i_frame_end = 1;
    tick(1);
    i_frame_end = 0;
    tick(2);
    @(posedge i_clk);
    #2 i_rst_n = 0;
    #1;
    check("arst_valid", o_rast_valid, 0);
    check("arst_tri", o_rast_tri, 0);
    check("arst_ready", o_tri_ready, 1);
    check("arst_done", o_frame_done, 0);
    exp_q.delete();
    stall = 0;
    tick(1);
    i_rst_n = 1;
    cnt0 = done_cnt;
    tick(30);
    check("post_rst_no_done", done_cnt, cnt0);
    starts_req = 0;
    sweeps_done = 0;
    frame_start(12'h00F);
    w = 0;
    while (!o_clearing && w < 10) begin tick(1); w++; end
    check("clear2_start", o_clearing, 1);
    tick(999);
    #1 i_rst_n = 0;
    #1;
    check("arst_clearing", o_clearing, 0);
    check("arst_fb_we", o_fb_we, 0);
    check("arst_fb_addr", o_fb_addr, 17'd3);
    starts_req = 0;
    sweeps_done = 0;
    tick(1);
    i_rst_n = 1;
    tick(30);
    check("no_resweep", o_clearing, 0);
    check("clear_abort_done", done_cnt, cnt0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
